// File: rtl/llmint_weight_streamer_if.sv
// Load and stream handshake bundle for the weight streamer.
// The master drives loads and consumes beats; the slave is the streamer.
interface llmint_weight_streamer_if #(
    parameter int unsigned ORIGINAL_PRECISION = 16,
    parameter int unsigned REDUCED_PRECISION  = 8,
    parameter int unsigned WEIGHT_DIM_0       = 8
);
    logic                                               wr_valid;
    logic                                               wr_ready;
    logic [ORIGINAL_PRECISION-1:0]                      wr_data;
    logic                                               start;
    logic [7:0]                                         num_passes;
    logic                                               weight_valid;
    logic                                               weight_ready;
    logic [WEIGHT_DIM_0-1:0][ORIGINAL_PRECISION-1:0]    weight_hp;
    logic [WEIGHT_DIM_0-1:0][REDUCED_PRECISION-1:0]     weight_lp;
    logic                                               weight_last;
    logic                                               weights_loaded;
    logic                                               busy;

    modport master (
        output wr_valid, wr_data, start, num_passes, weight_ready,
        input  wr_ready, weight_valid, weight_hp, weight_lp, weight_last,
               weights_loaded, busy
    );

    modport slave (
        input  wr_valid, wr_data, start, num_passes, weight_ready,
        output wr_ready, weight_valid, weight_hp, weight_lp, weight_last,
               weights_loaded, busy
    );
endinterface

// File: rtl/llmint_weight_streamer.sv
// Holds a WEIGHT_DIM_1 x WEIGHT_DIM_0 weight tile loaded word by word and
// streams it row by row, in full and reduced precision, for a number of passes.
module llmint_weight_streamer #(
    parameter int unsigned ORIGINAL_PRECISION = 16,
    parameter int unsigned REDUCED_PRECISION  = 8,
    parameter int unsigned WEIGHT_DIM_0       = 8,
    parameter int unsigned WEIGHT_DIM_1       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    llmint_weight_streamer_if.slave     bus_io
);

    localparam int unsigned OP        = ORIGINAL_PRECISION;
    localparam int unsigned RP        = REDUCED_PRECISION;
    localparam int unsigned NUM_WORDS = WEIGHT_DIM_0 * WEIGHT_DIM_1;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned ROW_W     = (WEIGHT_DIM_1 > 1) ? $clog2(WEIGHT_DIM_1) : 1;
    localparam int unsigned PASS_W    = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(WEIGHT_DIM_1 - 1);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_LOAD   = 2'd1,
        S_READY  = 2'd2,
        S_STREAM = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    widx_q,  widx_d;
    logic [ROW_W-1:0]    row_q,   row_d;
    logic [PASS_W-1:0]   pass_q,  pass_d;
    logic [PASS_W-1:0]   npass_q, npass_d;

    logic [OP-1:0]       mem_q [NUM_WORDS];

    logic                wr_ready_c;
    logic                weight_valid_c;
    logic                weight_last_c;
    logic                weights_loaded_c;
    logic                busy_c;
    logic                wr_fire;
    logic                beat_fire;

    logic [WEIGHT_DIM_0-1:0][OP-1:0] hp_c;
    logic [WEIGHT_DIM_0-1:0][RP-1:0] lp_c;
    logic [IDX_W-1:0]                rd_idx;

    assign wr_fire   = bus_io.wr_valid && wr_ready_c;
    assign beat_fire = weight_valid_c && bus_io.weight_ready;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            widx_q  <= '0;
            row_q   <= '0;
            pass_q  <= '0;
            npass_q <= '0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            row_q   <= row_d;
            pass_q  <= pass_d;
            npass_q <= npass_d;
        end
    end

    // Weight storage; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[widx_q] <= bus_io.wr_data;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        row_d   = row_q;
        pass_d  = pass_q;
        npass_d = npass_q;

        unique case (state_q)
            S_EMPTY: begin
                if (wr_fire) begin
                    widx_d  = IDX_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (wr_fire) begin
                    if (widx_q == LAST_IDX) begin
                        widx_d  = '0;
                        state_d = S_READY;
                    end else begin
                        widx_d  = widx_q + IDX_W'(1);
                    end
                end
            end
            S_READY: begin
                // A write in the same cycle as start wins and restarts loading
                if (wr_fire) begin
                    widx_d  = IDX_W'(1);
                    state_d = S_LOAD;
                end else if (bus_io.start && (bus_io.num_passes != '0)) begin
                    row_d   = '0;
                    pass_d  = '0;
                    npass_d = bus_io.num_passes;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (beat_fire) begin
                    if (row_q == LAST_ROW) begin
                        row_d  = '0;
                        pass_d = pass_q + PASS_W'(1);
                        if (pass_q == PASS_W'(npass_q - PASS_W'(1))) begin
                            state_d = S_READY;
                        end
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Status and handshake outputs decoded from the state register
    always_comb begin
        wr_ready_c       = 1'b0;
        weight_valid_c   = 1'b0;
        weight_last_c    = 1'b0;
        weights_loaded_c = 1'b0;
        busy_c           = 1'b0;

        unique case (state_q)
            S_EMPTY, S_LOAD: begin
                wr_ready_c = 1'b1;
            end
            S_READY: begin
                wr_ready_c       = 1'b1;
                weights_loaded_c = 1'b1;
            end
            S_STREAM: begin
                weight_valid_c   = 1'b1;
                busy_c           = 1'b1;
                weights_loaded_c = 1'b1;
                weight_last_c    = (row_q == LAST_ROW);
            end
            default: ;
        endcase
    end

    // Row select and quantization; the array is frozen while streaming so the beat holds under stall
    always_comb begin
        hp_c   = '0;
        lp_c   = '0;
        rd_idx = '0;
        for (int unsigned i = 0; i < WEIGHT_DIM_0; i++) begin
            rd_idx  = IDX_W'(32'(row_q) * WEIGHT_DIM_0 + i);
            hp_c[i] = mem_q[rd_idx];
            lp_c[i] = hp_c[i][OP-1 -: RP];
        end
    end

    assign bus_io.wr_ready       = wr_ready_c;
    assign bus_io.weight_valid   = weight_valid_c;
    assign bus_io.weight_last    = weight_last_c;
    assign bus_io.weights_loaded = weights_loaded_c;
    assign bus_io.busy           = busy_c;
    assign bus_io.weight_hp      = hp_c;
    assign bus_io.weight_lp      = lp_c;

endmodule

// File: tb/tb_llmint_weight_streamer.sv
// Scenario bench for the weight streamer against an array-based reference model.
module tb_llmint_weight_streamer;

    localparam int unsigned OP = 16;
    localparam int unsigned RP = 8;
    localparam int unsigned D0 = 8;
    localparam int unsigned D1 = 8;
    localparam int unsigned NW = D0 * D1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    llmint_weight_streamer_if #(
        .ORIGINAL_PRECISION(OP), .REDUCED_PRECISION(RP), .WEIGHT_DIM_0(D0)
    ) bus ();

    llmint_weight_streamer #(
        .ORIGINAL_PRECISION(OP), .REDUCED_PRECISION(RP),
        .WEIGHT_DIM_0(D0), .WEIGHT_DIM_1(D1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [OP-1:0] model [NW];

    function automatic logic [D0-1:0][OP-1:0] exp_hp(input int r);
        logic [D0-1:0][OP-1:0] v;
        for (int i = 0; i < int'(D0); i++) v[i] = model[r * int'(D0) + i];
        return v;
    endfunction

    function automatic logic [D0-1:0][RP-1:0] exp_lp(input int r);
        logic [D0-1:0][RP-1:0] v;
        logic signed [OP-1:0]  w;
        for (int i = 0; i < int'(D0); i++) begin
            w    = $signed(model[r * int'(D0) + i]);
            w    = w >>> (OP - RP);
            v[i] = w[RP-1:0];
        end
        return v;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < int'(NW); k++) model[k] = OP'($urandom);
    endtask

    task automatic load_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            @(negedge clk);
            bus.wr_valid = 1'b1;
            bus.wr_data  = model[k];
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_start(input int np);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.num_passes = 8'(np);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.num_passes = 8'd0;
    endtask

    // Entered at the negedge where the first beat should be presented; mode 0 ready, 1 toggle, 2 random
    task automatic stream_check(input int passes, input int mode, input string tag);
        int beats = 0;
        int cyc   = 0;
        int r;
        logic rdy;
        logic stalled = 1'b0;
        logic [D0-1:0][OP-1:0] prev_hp = '0;
        while (beats < passes * int'(D1) && cyc < 2000) begin
            r = beats % int'(D1);
            checks++;
            if ({bus.weight_valid, bus.busy, bus.wr_ready, bus.weights_loaded} !== 4'b1101) begin
                errors++;
                $display("FAIL %s status beat%0d got v/b/wr/ld=%b%b%b%b exp 1101", tag, beats,
                         bus.weight_valid, bus.busy, bus.wr_ready, bus.weights_loaded);
            end
            checks++;
            if (bus.weight_hp !== exp_hp(r)) begin
                errors++;
                $display("FAIL %s hp beat%0d got %h exp %h", tag, beats, bus.weight_hp, exp_hp(r));
            end
            checks++;
            if (bus.weight_lp !== exp_lp(r)) begin
                errors++;
                $display("FAIL %s lp beat%0d got %h exp %h", tag, beats, bus.weight_lp, exp_lp(r));
            end
            checks++;
            if (bus.weight_last !== (r == int'(D1) - 1)) begin
                errors++;
                $display("FAIL %s last beat%0d got %b exp %b", tag, beats, bus.weight_last, (r == int'(D1) - 1));
            end
            if (stalled) begin
                checks++;
                if (bus.weight_hp !== prev_hp) begin
                    errors++;
                    $display("FAIL %s stall_hold beat%0d got %h exp %h", tag, beats, bus.weight_hp, prev_hp);
                end
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.weight_ready = rdy;
            if (rdy) beats++;
            stalled = !rdy;
            prev_hp = bus.weight_hp;
            @(negedge clk);
            cyc++;
        end
        bus.weight_ready = 1'b0;
        checks++;
        if (beats != passes * int'(D1)) begin
            errors++;
            $display("FAIL %s timeout beats got %0d exp %0d", tag, beats, passes * int'(D1));
        end
        checks++;
        if ({bus.weight_valid, bus.busy, bus.weights_loaded} !== 3'b001) begin
            errors++;
            $display("FAIL %s end_status got v/b/ld=%b%b%b exp 001", tag,
                     bus.weight_valid, bus.busy, bus.weights_loaded);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.wr_ready, bus.weight_valid, bus.busy, bus.weights_loaded, bus.weight_last} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_status got wr/v/b/ld/last=%b%b%b%b%b exp 10000", bus.wr_ready,
                     bus.weight_valid, bus.busy, bus.weights_loaded, bus.weight_last);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int k = 0; k < int'(NW); k++) model[k] = OP'(k);
        load_range(0, int'(NW) - 1);
        checks++;
        if (bus.weights_loaded !== 1'b1) begin
            errors++;
            $display("FAIL basic_loaded got %b exp 1", bus.weights_loaded);
        end
        do_start(1);
        stream_check(1, 0, "basic");
    endtask

    task automatic test_quant();
        logic [3:0][RP-1:0] got;
        fill_random();
        model[0] = 16'h8100;
        model[1] = 16'h7FFF;
        model[2] = 16'hFFFF;
        model[3] = 16'h0080;
        load_range(0, int'(NW) - 1);
        do_start(1);
        got = bus.weight_lp[3:0];
        checks++;
        if (got !== {8'h00, 8'hFF, 8'h7F, 8'h81}) begin
            errors++;
            $display("FAIL quant_consts got %h exp 00ff7f81", got);
        end
        stream_check(1, 0, "quant");
    endtask

    task automatic test_backpressure();
        fill_random();
        load_range(0, int'(NW) - 1);
        do_start(2);
        stream_check(2, 1, "backpressure");
    endtask

    task automatic test_random_stream();
        for (int t = 0; t < 3; t++) begin
            fill_random();
            load_range(0, int'(NW) - 1);
            do_start(int'($urandom_range(1, 3)) == 0 ? 1 : 0);
        end
    endtask

    task automatic test_random_passes();
        int np;
        for (int t = 0; t < 3; t++) begin
            fill_random();
            load_range(0, int'(NW) - 1);
            np = int'($urandom_range(1, 3));
            do_start(np);
            stream_check(np, 2, "random");
        end
    endtask

    task automatic test_collision();
        logic [OP-1:0] w0;
        fill_random();
        load_range(0, int'(NW) - 1);
        w0 = OP'($urandom);
        @(negedge clk);
        bus.wr_valid   = 1'b1;
        bus.wr_data    = w0;
        bus.start      = 1'b1;
        bus.num_passes = 8'd1;
        @(negedge clk);
        bus.wr_valid   = 1'b0;
        bus.start      = 1'b0;
        bus.num_passes = 8'd0;
        model[0]       = w0;
        checks++;
        if ({bus.weights_loaded, bus.weight_valid, bus.busy, bus.wr_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL collision_next got ld/v/b/wr=%b%b%b%b exp 0001", bus.weights_loaded,
                     bus.weight_valid, bus.busy, bus.wr_ready);
        end
        load_range(1, int'(NW) - 2);
        checks++;
        if (bus.weights_loaded !== 1'b0) begin
            errors++;
            $display("FAIL collision_62 loaded got %b exp 0", bus.weights_loaded);
        end
        load_range(int'(NW) - 1, int'(NW) - 1);
        checks++;
        if (bus.weights_loaded !== 1'b1) begin
            errors++;
            $display("FAIL collision_63 loaded got %b exp 1", bus.weights_loaded);
        end
        do_start(1);
        stream_check(1, 0, "collision");
    endtask

    task automatic test_ignored_start();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_start(1);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bus.weight_valid, bus.busy} !== 2'b00) begin
                errors++;
                $display("FAIL start_empty c%0d got v/b=%b%b exp 00", c, bus.weight_valid, bus.busy);
            end
            @(negedge clk);
        end
        fill_random();
        load_range(0, 9);
        do_start(1);
        checks++;
        if ({bus.weight_valid, bus.weights_loaded} !== 2'b00) begin
            errors++;
            $display("FAIL start_partial got v/ld=%b%b exp 00", bus.weight_valid, bus.weights_loaded);
        end
        load_range(10, int'(NW) - 1);
        do_start(0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bus.weight_valid, bus.busy, bus.weights_loaded} !== 3'b001) begin
                errors++;
                $display("FAIL start_zero c%0d got v/b/ld=%b%b%b exp 001", c,
                         bus.weight_valid, bus.busy, bus.weights_loaded);
            end
            @(negedge clk);
        end
        do_start(1);
        stream_check(1, 0, "after_ignored");
    endtask

    task automatic test_reset_mid_stream();
        fill_random();
        load_range(0, int'(NW) - 1);
        do_start(1);
        bus.weight_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.weight_hp !== exp_hp(3)) begin
            errors++;
            $display("FAIL midrst_beat3 got %h exp %h", bus.weight_hp, exp_hp(3));
        end
        rst              = 1'b1;
        bus.weight_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.weight_valid, bus.busy, bus.weights_loaded, bus.wr_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_status got v/b/ld/wr=%b%b%b%b exp 0001", bus.weight_valid,
                     bus.busy, bus.weights_loaded, bus.wr_ready);
        end
        do_start(1);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({bus.weight_valid, bus.busy} !== 2'b00) begin
                errors++;
                $display("FAIL midrst_start c%0d got v/b=%b%b exp 00", c, bus.weight_valid, bus.busy);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.wr_valid     = 1'b0;
        bus.wr_data      = '0;
        bus.start        = 1'b0;
        bus.num_passes   = 8'd0;
        bus.weight_ready = 1'b0;
        test_reset();
        test_basic();
        test_quant();
        test_backpressure();
        test_random_passes();
        test_collision();
        test_ignored_start();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/llmint_weight_streamer.md
LLMINT_WEIGHT_STREAMER -- requirements
Module: llmint_weight_streamer

Interface
REQ-001 SHALL have parameter ORIGINAL_PRECISION, default 16, full-precision weight width in bits.
REQ-002 SHALL have parameter REDUCED_PRECISION, default 8, quantized weight width; must be less than ORIGINAL_PRECISION.
REQ-003 SHALL have parameter WEIGHT_DIM_0, default 8, elements per beat (one weight row).
REQ-004 SHALL have parameter WEIGHT_DIM_1, default 8, rows (beats) per pass.
REQ-005 SHALL have one clock and synchronous, active-high reset, stated as: clk  input  1  clock, all logic on rising edge; rst  input  1  synchronous active-high reset.
REQ-006 SHALL have ports:
 wr_valid  input  1  load word valid.
 wr_ready  output  1  load word accepted when high with wr_valid.
 wr_data  input  ORIGINAL_PRECISION  signed weight word, row-major order (row 0 element 0 first).
 start  input  1  request streaming.
 num_passes  input  8  passes to stream, sampled with start.
 weight_valid  output  1  beat valid.
 weight_ready  input  1  consumer accepts beat.
 weight_hp  output  WEIGHT_DIM_0 x ORIGINAL_PRECISION  signed full-precision row.
 weight_lp  output  WEIGHT_DIM_0 x REDUCED_PRECISION  signed quantized row.
 weight_last  output  1  high on final row of each pass.
 weights_loaded  output  1  complete weight set held.
 busy  output  1  streaming in progress.

Function
REQ-007 SHALL hold WEIGHT_DIM_0*WEIGHT_DIM_1 words in an internal register array; a write index counts 0..WEIGHT_DIM_0*WEIGHT_DIM_1-1.
REQ-008 SHALL implement states EMPTY, LOAD, READY, STREAM.
REQ-009 EMPTY: wr_ready=1; accepted word stored at index 0, index->1, go LOAD; start ignored.
REQ-010 LOAD: wr_ready=1; each accepted word stored at index, index++; on acceptance of final word index->0, go READY; start ignored.
REQ-011 READY: wr_ready=1, weights_loaded=1; accepted word restarts loading at index 0 (weights_loaded drops next cycle, state LOAD); start with num_passes!=0 and no wr_valid goes STREAM, row=0, pass=0; start with num_passes==0 ignored.
REQ-012 wr_valid and start in the same READY cycle: the write wins, start is dropped.
REQ-013 STREAM: wr_ready=0, busy=1, weight_valid=1, weights_loaded=1; start ignored.
REQ-014 Beat data SHALL be row r: weight_hp[i]=array[r*WEIGHT_DIM_0+i] for i in 0..WEIGHT_DIM_0-1.
REQ-015 weight_lp[i] SHALL equal weight_hp[i] arithmetically shifted right by ORIGINAL_PRECISION-REDUCED_PRECISION, truncated to REDUCED_PRECISION bits (the top REDUCED_PRECISION bits).
REQ-016 weight_last SHALL be high only while weight_valid and r==WEIGHT_DIM_1-1.
REQ-017 weight_valid, weight_hp, weight_lp, weight_last SHALL be stable while weight_valid=1 and weight_ready=0.
REQ-018 On handshake: if r<WEIGHT_DIM_1-1 then r++; else r->0 and pass++; if pass was num_passes-1 go READY.
REQ-019 Latency: start accepted in cycle t -> weight_valid=1 in cycle t+1; back-to-back beats when weight_ready held high (one beat per cycle).
REQ-020 Leaving STREAM: weight_valid=0 and busy=0 in the cycle after the final handshake; weights retained.

Reset
REQ-021 On rst: state EMPTY, write index 0, r 0, pass 0, weight_valid 0, weight_last 0, busy 0, weights_loaded 0, wr_ready 1 next cycle; array contents not reset (don't care).
REQ-022 rst mid-LOAD or mid-STREAM SHALL abort immediately to EMPTY; weights must be reloaded before streaming.

Verification
REQ-023 Load 64 words value k (k=0..63), start, num_passes=1, weight_ready=1 -> 8 consecutive beats, beat r weight_hp[i]=8r+i, weight_last only on beat 7, then weight_valid=0, busy=0.
REQ-024 Quantization: words 16'h8100, 16'h7FFF, 16'hFFFF, 16'h0080 -> weight_lp 8'h81, 8'h7F, 8'hFF, 8'h00.
REQ-025 Backpressure: weight_ready toggled 1/0 every cycle, num_passes=2 -> 16 beats total, data unchanged across stall cycles, weight_last on beats 8 and 16.
REQ-026 start in EMPTY or after 10 of 64 words -> weight_valid stays 0; start with num_passes=0 in READY -> no beats.
REQ-027 wr_valid and start same cycle in READY -> no streaming, weights_loaded=0 next cycle, 63 more words needed to reach READY.
REQ-028 rst asserted at beat 3 of a stream -> next cycle weight_valid=0, busy=0, weights_loaded=0, wr_ready=1; start before reload is ignored.
